// File: rtl/alu_exec.sv
// Execute stage feeding the register-file write port: single-cycle ALU plus an optional
// iterative MUL/DIVU/REMU engine, compiled in only when ALU_EXEC_MULDIV_EN is defined.
module alu_exec #(
    parameter int width       = 32,
    parameter int total_reg   = 20,
    parameter int address_reg = $clog2(total_reg)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             op,
    input  logic [width-1:0]       a,
    input  logic [width-1:0]       b,
    input  logic [address_reg-1:0] rd_addr,
    output logic                   wenable,
    output logic [address_reg-1:0] rd,
    output logic [width-1:0]       rd_in,
    output logic                   busy,
    output logic                   illegal_op
);

    localparam int SHW = $clog2(width);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    logic                   r_wenable;
    logic [address_reg-1:0] r_rd;
    logic [width-1:0]       r_rd_in;
    logic                   r_illegal;

    logic [width-1:0]       w_result;
    logic                   w_legal;
    logic                   w_multi;
    logic                   w_accept;
    logic [SHW-1:0]         w_shamt;

    assign w_shamt  = b[SHW-1:0];
    assign w_accept = in_valid && in_ready;

    // Single-cycle datapath and opcode classification
    always_comb begin
        w_result = '0;
        w_legal  = 1'b1;
        w_multi  = 1'b0;
        case (op)
            OP_ADD:  w_result = a + b;
            OP_SUB:  w_result = a - b;
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_SLL:  w_result = a << w_shamt;
            OP_SRL:  w_result = a >> w_shamt;
            OP_SRA:  w_result = $signed(a) >>> w_shamt;
            OP_SLT:  w_result = {{(width-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_result = {{(width-1){1'b0}}, (a < b)};
            OP_MUL, OP_DIVU, OP_REMU: begin
`ifdef ALU_EXEC_MULDIV_EN
                w_multi = 1'b1;
`else
                w_legal = 1'b0;
`endif
            end
            default: w_legal = 1'b0;
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SHW-1:0]         r_cnt;
    logic [width-1:0]       r_opa;   // multiplicand, or dividend shifting out / quotient shifting in
    logic [width-1:0]       r_opb;   // multiplier, or divisor
    logic [width-1:0]       r_acc;   // product, or partial remainder
    logic                   r_is_mul;
    logic                   r_take_quot;
    logic [address_reg-1:0] r_rd_addr;

    logic [width:0]         w_rem_shift;
    logic [width:0]         w_diff;
    logic [width-1:0]       w_opa_nxt;
    logic [width-1:0]       w_opb_nxt;
    logic [width-1:0]       w_acc_nxt;
    logic [width-1:0]       w_eng_result;

    // One shift-add or restoring-divide step per cycle
    always_comb begin
        w_rem_shift = {r_acc, r_opa[width-1]};
        w_diff      = w_rem_shift - {1'b0, r_opb};
        if (r_is_mul) begin
            w_acc_nxt = r_opb[0] ? (r_acc + r_opa) : r_acc;
            w_opa_nxt = {r_opa[width-2:0], 1'b0};
            w_opb_nxt = {1'b0, r_opb[width-1:1]};
        end else begin
            w_opb_nxt = r_opb;
            if (!w_diff[width]) begin
                w_acc_nxt = w_diff[width-1:0];
                w_opa_nxt = {r_opa[width-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_shift[width-1:0];
                w_opa_nxt = {r_opa[width-2:0], 1'b0};
            end
        end
        w_eng_result = r_take_quot ? w_opa_nxt : w_acc_nxt;
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    // Issue control, iterative engine FSM and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wenable   <= 1'b0;
            r_rd        <= '0;
            r_rd_in     <= '0;
            r_illegal   <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_is_mul    <= 1'b0;
            r_take_quot <= 1'b0;
            r_rd_addr   <= '0;
`endif
        end else begin
            r_wenable <= 1'b0;
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal && !w_multi && (rd_addr != '0)) begin
                r_wenable <= 1'b1;
                r_rd      <= rd_addr;
                r_rd_in   <= w_result;
            end
`ifdef ALU_EXEC_MULDIV_EN
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_multi) begin
                        r_state     <= S_ITER;
                        r_cnt       <= '0;
                        r_opa       <= a;
                        r_opb       <= b;
                        r_acc       <= '0;
                        r_is_mul    <= (op == OP_MUL);
                        r_take_quot <= (op == OP_DIVU);
                        r_rd_addr   <= rd_addr;
                    end
                end
                S_ITER: begin
                    r_opa <= w_opa_nxt;
                    r_opb <= w_opb_nxt;
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // Final step: strobe lands in the WB cycle with the completed result
                    if (r_cnt == SHW'(width-1)) begin
                        r_state <= S_WB;
                        if (r_rd_addr != '0) begin
                            r_wenable <= 1'b1;
                            r_rd      <= r_rd_addr;
                            r_rd_in   <= w_eng_result;
                        end
                    end
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
`endif
        end
    end

    assign wenable    = r_wenable;
    assign rd         = r_rd;
    assign rd_in      = r_rd_in;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected writes (address, data, due cycle) are queued at
// issue and compared when the write strobe is due; behaviour follows ALU_EXEC_MULDIV_EN.
module tb_alu_exec;

    localparam int W  = 32;
    localparam int AW = $clog2(20);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd_addr;
    logic          wenable;
    logic [AW-1:0] rd;
    logic [W-1:0]  rd_in;
    logic          busy;
    logic          illegal_op;

    typedef struct {
        int            due;
        logic [AW-1:0] r;
        logic [W-1:0]  d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_exec dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .rd_addr    (rd_addr),
        .wenable    (wenable),
        .rd         (rd),
        .rd_in      (rd_in),
        .busy       (busy),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        logic [4:0]   sh;
        logic [W-1:0] t;
        sh = y[4:0];
        case (o)
            4'd0:  t = x + y;
            4'd1:  t = x - y;
            4'd2:  t = x & y;
            4'd3:  t = x | y;
            4'd4:  t = x ^ y;
            4'd5:  t = x << sh;
            4'd6:  t = x >> sh;
            4'd7:  t = $signed(x) >>> sh;
            4'd8:  t = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9:  t = (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_MULDIV_EN
            4'd10: t = x * y;
            4'd11: t = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            4'd12: t = (y == 32'd0) ? x : x % y;
`endif
            default: return {1'b0, {W{1'b0}}};
        endcase
        return {1'b1, t};
    endfunction

    // Drive one op, wait until accepted, then queue the expected write with its due cycle
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [AW-1:0] r, input bit exp_en);
        logic [W:0] m;
        int         guard;
        int         lat;
        exp_t       e;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        rd_addr  = r;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("issue_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m   = model(o, x, y);
        lat = (o >= 4'd10 && o <= 4'd12) ? 33 : 1;
        if (exp_en && m[W] && (r != '0)) begin
            e.due = cyc + lat - 1;
            e.r   = r;
            e.d   = m[W-1:0];
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard: every write must be due this cycle, and every due write must appear
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_strobe", 64'(wenable), 64'd1);
            check("wr_addr", 64'(rd), 64'(e.r));
            check("wr_data", 64'(rd_in), 64'(e.d));
        end else if (wenable) begin
            check("wr_unexpected", 64'(wenable), 64'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int low;
        int bsy;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'd0;
        a        = '0;
        b        = '0;
        rd_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wenable", 64'(wenable), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_rd_in", 64'(rd_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_illegal", 64'(illegal_op), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // back-to-back single-cycle ops
        issue(4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
        issue(4'd1, 32'd0, 32'd1, 5'd4, 1'b1);
        issue(4'd7, 32'h8000_0000, 32'h21, 5'd5, 1'b1);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd8, 1'b1);
        issue(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd9, 1'b1);
        issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd10, 1'b1);
        issue(4'd5, 32'h8000_0003, 32'h24, 5'd11, 1'b1);
        issue(4'd6, 32'h8000_0003, 32'h1F, 5'd12, 1'b1);
        issue(4'd0, 32'hFFFF_FFFF, 32'd2, 5'd19, 1'b1);
        repeat (3) @(negedge clk);

        // x0 destination and illegal opcode: no write
        issue(4'd0, 32'd1, 32'd2, 5'd0, 1'b1);
        issue(4'd14, 32'd1, 32'd2, 5'd3, 1'b1);
        @(negedge clk);
        check("illegal_pulse", 64'(illegal_op), 64'd1);
        @(negedge clk);
        check("illegal_clear", 64'(illegal_op), 64'd0);

`ifdef ALU_EXEC_MULDIV_EN
        issue(4'd10, 32'h0001_0000, 32'h0001_0001, 5'd5, 1'b1);
        low = 0;
        bsy = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (in_ready) break;
            low++;
            if (busy) bsy++;
            in_valid = (k % 3 == 0);
            op       = 4'd0;
            a        = 32'd1;
            b        = 32'd1;
            rd_addr  = 5'd7;
        end
        in_valid = 1'b0;
        check("mul_stall_cycles", 64'(low), 64'd33);
        check("mul_busy_cycles", 64'(bsy), 64'd33);

        issue(4'd11, 32'd100, 32'd7, 5'd1, 1'b1);
        issue(4'd12, 32'd100, 32'd7, 5'd2, 1'b1);
        issue(4'd11, 32'd9, 32'd0, 5'd3, 1'b1);
        issue(4'd12, 32'd9, 32'd0, 5'd4, 1'b1);
        issue(4'd10, 32'hDEAD_BEEF, 32'h1234_5679, 5'd6, 1'b1);
        issue(4'd11, 32'hFFFF_FFFF, 32'h0000_0003, 5'd7, 1'b1);
        repeat (40) @(negedge clk);

        // reset during a divide aborts it without a write
        issue(4'd11, 32'd100, 32'd7, 5'd6, 1'b0);
        repeat (9) @(negedge clk);
        check("div_busy_mid", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
`else
        issue(4'd10, 32'd3, 32'd4, 5'd5, 1'b1);
        @(negedge clk);
        check("mul_off_illegal", 64'(illegal_op), 64'd1);
        check("mul_off_busy", 64'(busy), 64'd0);
        check("mul_off_ready", 64'(in_ready), 64'd1);
`endif
        issue(4'd0, 32'd2, 32'd3, 5'd9, 1'b1);
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage that sits directly upstream of the register file write port.
- Consumes the operand values read from the register file (out1/out2) plus a decoded opcode and destination address.
- Drives the register file's wenable/rd/rd_in write interface.
- Single-cycle ALU ops issue at one per cycle; multiply/divide run on an iterative multi-cycle engine that stalls issue.

Parameters:
- width, 32, operand/result data width; must match register file width.
- total_reg, 20, number of architectural registers.
- address_reg, $clog2(total_reg), destination address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream presents an operation this cycle
- in_ready  output  1  stage can accept an operation this cycle
- op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 DIVU, 12 REMU, 13-15 illegal
- a  input  width  operand 1 (register file out1)
- b  input  width  operand 2 (register file out2)
- rd_addr  input  address_reg  destination register
- wenable  output  1  write strobe to register file
- rd  output  address_reg  write address to register file
- rd_in  output  width  write data to register file
- busy  output  1  multi-cycle engine active
- illegal_op  output  1  one-cycle pulse, illegal opcode accepted

Behaviour:
- Accept = in_valid && in_ready, sampled at posedge clk.
- Reset: state=IDLE; wenable=0, rd=0, rd_in=0, busy=0, illegal_op=0, in_ready=1 on the first cycle after reset.
- State machine has three states: IDLE, ITER, WB.
- IDLE, in_ready=1:
  - Single-cycle op (0-9) accepted: result, rd registered; wenable=1 on the next cycle. Throughput 1 op/cycle, latency 1.
  - MUL/DIVU/REMU accepted: latch a, b, rd_addr, op; iteration counter=0; go to ITER.
- ITER, in_ready=0, busy=1:
  - One bit per cycle for exactly width cycles.
  - MUL: shift-add; result is the low width bits of a*b, unsigned.
  - DIVU/REMU: restoring division.
  - After counter reaches width-1, go to WB.
- WB, in_ready=0, busy=1: wenable=1 with the final result; next state IDLE. Multi-cycle latency from accept to wenable = width+1 cycles (33 at default).
- Shifts use b[$clog2(width)-1:0] only. SRA is arithmetic.
- SLT (signed) and SLTU (unsigned) produce 0 or 1, zero-extended.
- ADD/SUB/MUL wrap modulo 2^width; no overflow flag.
- Divide by zero: DIVU result = all ones; REMU result = a. Takes the same width+1 cycles as any other divide.
- rd_addr==0: operation executes normally, but wenable stays 0 (x0 is never written).
- Illegal opcode: accepted; illegal_op=1 for one cycle; no write.
- wenable is asserted for exactly one cycle per write. No back-pressure on the write side.
- rd/rd_in hold their last values when wenable=0.
- in_valid while in_ready=0: ignored. Upstream must hold the op until accepted.
- Reset mid-ITER or mid-WB: operation aborted, no write issued, state returns to IDLE.

Optional Feature:
- Macro: ALU_EXEC_MULDIV_EN.
- Defined: MUL/DIVU/REMU behave as above.
- Undefined:
  - Opcodes 10-12 are treated as illegal (illegal_op pulse, no write).
  - The ITER/WB engine is not synthesised; busy is tied 0 and in_ready is tied 1.

Test Plan:
- Reset, then ADD a=5 b=7 rd=3 -> next cycle wenable=1, rd=3, rd_in=12. Back-to-back SUB a=0 b=1 rd=4 -> rd_in=0xFFFFFFFF the following cycle.
- SRA a=0x80000000 b=0x21 -> rd_in=0xC0000000 (shift amount 1). SLT a=-1 b=1 -> 1. SLTU a=-1 b=1 -> 0.
- MUL a=0x10000 b=0x10001 rd=5 -> in_ready=0 for 33 cycles; wenable on cycle 33 after accept with rd_in=0x00010000. in_valid pulses during busy are ignored.
- DIVU a=100 b=7 -> 14. REMU a=100 b=7 -> 2. DIVU a=9 b=0 -> 0xFFFFFFFF. REMU a=9 b=0 -> 9.
- ADD with rd=0 -> wenable stays 0. op=14 -> illegal_op pulse, no write. With ALU_EXEC_MULDIV_EN undefined, op=10 -> illegal_op pulse, busy stays 0.
- rst asserted at cycle 10 of a DIVU -> no wenable; in_ready=1 the cycle after reset deasserts; a following ADD completes normally.
